// File: rtl/rv_pkg.sv
// Shared encodings and combinational helpers for the mini-rv single-cycle core.
package rv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {IMM_I, IMM_B, IMM_J, IMM_U} imm_type_e;

  // Opcode bits are never part of an immediate, so only instr[31:7] is passed in.
  function automatic logic [31:0] gen_imm(input logic [31:7] ins, input imm_type_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_B:   imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      default: imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      default:  y = a + b;
    endcase
    return y;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic t;
    case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = ($signed(a) < $signed(b));
      F3_BGE:  t = ($signed(a) >= $signed(b));
      F3_BLTU: t = (a < b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rv_imem.sv
// Instruction ROM with a combinational word read; contents come from an init file or the bench.
module rv_imem #(
  parameter int IMEM_WORDS = 64
) (
  input  logic [$clog2(IMEM_WORDS)-1:0] addr,
  output logic [31:0]                   rdata
);

  logic [31:0] mem [IMEM_WORDS];

  assign rdata = mem[addr];

endmodule

// File: rtl/rv_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 hardwired to 0.
module rv_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] registers [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (write_en && (waddr != 5'd0)) begin
      registers[waddr] <= wdata;
    end
  end

  // No bypass: a same-cycle write becomes visible only after the edge.
  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : registers[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : registers[raddr_b];

endmodule

// File: rtl/rv_core_top.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and writeback all complete in one clock.
module rv_core_top
  import rv_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset
);

  localparam int AW = $clog2(IMEM_WORDS);

  logic [31:0] pc, next_pc, pc_plus4;
  logic [31:0] instr, imm, op_b, alu_out, result;
  logic [31:0] rs1_data, rs2_data;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        write_en, use_imm, is_branch, is_jal, is_lui, take;
  alu_op_e     alu_op;
  imm_type_e   imm_sel;

  rv_imem #(.IMEM_WORDS(IMEM_WORDS)) i_mem (
    .addr  (pc[AW+1:2]),
    .rdata (instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Anything not matched below leaves write_en low and falls through to pc+4.
  always_comb begin
    write_en  = 1'b0;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_lui    = 1'b0;
    alu_op    = ALU_ADD;
    imm_sel   = IMM_I;
    case (opcode)
      OP: begin
        if (funct7 == F7_BASE) begin
          write_en = 1'b1;
          case (funct3)
            F3_ADD_SUB: alu_op = ALU_ADD;
            F3_SLT:     alu_op = ALU_SLT;
            F3_SLTU:    alu_op = ALU_SLTU;
            F3_XOR:     alu_op = ALU_XOR;
            F3_OR:      alu_op = ALU_OR;
            F3_AND:     alu_op = ALU_AND;
            default:    write_en = 1'b0;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          write_en = 1'b1;
          alu_op   = ALU_SUB;
        end
      end
      OP_IMM: begin
        write_en = 1'b1;
        use_imm  = 1'b1;
        case (funct3)
          F3_ADD_SUB: alu_op = ALU_ADD;
          F3_SLT:     alu_op = ALU_SLT;
          F3_SLTU:    alu_op = ALU_SLTU;
          F3_XOR:     alu_op = ALU_XOR;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default:    write_en = 1'b0;
        endcase
      end
      BRANCH: begin
        imm_sel   = IMM_B;
        is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      JAL: begin
        write_en = 1'b1;
        is_jal   = 1'b1;
        imm_sel  = IMM_J;
      end
      LUI: begin
        write_en = 1'b1;
        is_lui   = 1'b1;
        imm_sel  = IMM_U;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm      = gen_imm(instr[31:7], imm_sel);
    op_b     = use_imm ? imm : rs2_data;
    alu_out  = alu(alu_op, rs1_data, op_b);
    take     = is_branch && branch_taken(funct3, rs1_data, rs2_data);
    pc_plus4 = pc + 32'd4;
    result   = is_jal ? pc_plus4 : (is_lui ? imm : alu_out);
    next_pc  = (take || is_jal) ? pc + imm : pc_plus4;
  end

  rv_reg_file reg_file (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .waddr    (rd),
    .wdata    (result),
    .raddr_a  (rs1),
    .raddr_b  (rs2),
    .rdata_a  (rs1_data),
    .rdata_b  (rs2_data)
  );

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= next_pc;
  end

endmodule

// File: tb/tb_rv_core_top.sv
// Directed-program bench for rv_core_top with an instruction-level reference model.
module tb_rv_core_top;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rv_core_top #(.IMEM_WORDS(64), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  logic [31:0] prog   [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] exp_q [$];
  bit          active = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    logic [11:0] v;
    v = imm[11:0];
    return {v, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] v;
    v = imm[12:0];
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [20:0] v;
    v = imm[20:0];
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm20, input logic [4:0] rd);
    return {imm20, rd, 7'h37};
  endfunction

  // ---------------- reference model: one instruction per call ----------------
  task automatic model_step();
    logic [31:0] ins, a, b, val, npc, imm_i, imm_b, imm_j;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    bit          wr, tk;
    ins   = prog[m_pc[7:2]];
    op    = ins[6:0];   rd  = ins[11:7];  f3 = ins[14:12];
    rs1   = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a     = m_regs[rs1];
    b     = m_regs[rs2];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc   = m_pc + 32'd4;
    wr    = 1'b0;
    val   = 32'd0;
    tk    = 1'b0;
    if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
      wr = 1'b1; val = a - b;
    end else if (op == 7'h33 || op == 7'h13) begin
      if (op == 7'h13) b = imm_i;
      if (op == 7'h13 || f7 == 7'h00) begin
        wr = 1'b1;
        case (f3)
          3'd0: val = a + b;
          3'd2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: val = (a < b) ? 32'd1 : 32'd0;
          3'd4: val = a ^ b;
          3'd6: val = a | b;
          3'd7: val = a & b;
          default: wr = 1'b0;
        endcase
      end
    end else if (op == 7'h63) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) < $signed(b));
        3'd5: tk = ($signed(a) >= $signed(b));
        3'd6: tk = (a < b);
        3'd7: tk = (a >= b);
        default: tk = 1'b0;
      endcase
      if (tk) npc = m_pc + imm_b;
    end else if (op == 7'h6f) begin
      wr = 1'b1; val = m_pc + 32'd4; npc = m_pc + imm_j;
    end else if (op == 7'h37) begin
      wr = 1'b1; val = {ins[31:12], 12'd0};
    end
    if (wr && rd != 5'd0) m_regs[rd] = val;
    m_pc = npc;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (active && exp_q.size() > 0) begin
      logic [31:0] e;
      int          first_bad;
      e = exp_q.pop_front();
      n_cmp++;
      if (dut.pc !== e) begin
        n_bad++;
        $display("FAIL pc_track: pc=%h expected=%h at %0t", dut.pc, e, $time);
      end
      n_cmp++;
      first_bad = -1;
      for (int i = 0; i < 32; i++)
        if (first_bad < 0 && dut.reg_file.registers[i] !== m_regs[i]) first_bad = i;
      if (first_bad >= 0) begin
        n_bad++;
        $display("FAIL regs_track: x%0d=%h expected=%h at %0t", first_bad,
                 dut.reg_file.registers[first_bad], m_regs[first_bad], $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h00000013;
  endtask

  task automatic reset_core();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    exp_q.push_back(m_pc);
    active = 1'b1;
  endtask

  task automatic start_prog();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) dut.i_mem.mem[i] = prog[i];
    reset_core();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_step();
      exp_q.push_back(m_pc);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Sum loop, hand-encoded so the encoders are not trusted here.
    clear_prog();
    prog[0] = 32'h00500093;  // addi x1,x0,5
    prog[1] = 32'h00000113;  // addi x2,x0,0
    prog[2] = 32'h00110133;  // add  x2,x2,x1
    prog[3] = 32'hFFF08093;  // addi x1,x1,-1
    prog[4] = 32'hFE009CE3;  // bne  x1,x0,-8
    prog[5] = 32'h00000013;  // nop
    prog[6] = 32'hFE000EE3;  // beq  x0,x0,-4
    start_prog();
    check32("reset_pc", dut.pc, 32'h0);
    check32("reset_x1", dut.reg_file.registers[1], 32'h0);
    step(50);
    check32("sum_x1", dut.reg_file.registers[1], 32'd0);
    check32("sum_x2", dut.reg_file.registers[2], 32'd15);
    check32("sum_pc_even", dut.pc, 32'h18);
    step(1);
    check32("sum_pc_odd", dut.pc, 32'h14);

    // Mid-run reset during the loop.
    start_prog();
    step(8);
    reset_core();
    check32("midrst_pc", dut.pc, 32'h0);
    check32("midrst_x1", dut.reg_file.registers[1], 32'h0);
    check32("midrst_x2", dut.reg_file.registers[2], 32'h0);
    step(50);
    check32("midrst_sum_x2", dut.reg_file.registers[2], 32'd15);

    // x0 protection.
    clear_prog();
    prog[0] = enc_i(9, 0, 0, 3);       // addi x3,x0,9
    prog[1] = enc_i(7, 0, 0, 0);       // addi x0,x0,7
    prog[2] = enc_r(0, 0, 0, 0, 3);    // add  x3,x0,x0
    start_prog();
    step(2);
    check32("x0_after_addi", dut.reg_file.registers[0], 32'd0);
    check32("x3_before_add", dut.reg_file.registers[3], 32'd9);
    step(1);
    check32("x3_after_add", dut.reg_file.registers[3], 32'd0);

    // Signed vs unsigned compare and branch.
    clear_prog();
    prog[0] = enc_i(-1, 0, 0, 1);      // addi x1,x0,-1
    prog[1] = enc_i(1, 0, 0, 2);       // addi x2,x0,1
    prog[2] = enc_r(0, 2, 1, 2, 3);    // slt  x3,x1,x2
    prog[3] = enc_r(0, 2, 1, 3, 4);    // sltu x4,x1,x2
    prog[4] = enc_b(8, 2, 1, 4);       // blt  x1,x2,+8
    prog[5] = enc_i(9, 0, 0, 5);       // skipped
    prog[6] = enc_i(3, 0, 0, 6);       // addi x6,x0,3
    start_prog();
    step(6);
    check32("slt_x3", dut.reg_file.registers[3], 32'd1);
    check32("sltu_x4", dut.reg_file.registers[4], 32'd0);
    check32("blt_skip_x5", dut.reg_file.registers[5], 32'd0);
    check32("blt_x6", dut.reg_file.registers[6], 32'd3);
    check32("blt_pc", dut.pc, 32'h1C);

    // LUI and JAL.
    clear_prog();
    prog[0] = enc_u(20'h12345, 5);     // lui x5,0x12345
    prog[4] = enc_j(8, 6);             // jal x6,+8 at 0x10
    prog[5] = enc_i(1, 0, 0, 7);       // skipped
    start_prog();
    step(5);
    check32("lui_x5", dut.reg_file.registers[5], 32'h12345000);
    check32("jal_x6", dut.reg_file.registers[6], 32'h14);
    check32("jal_pc", dut.pc, 32'h18);
    check32("jal_skip_x7", dut.reg_file.registers[7], 32'h0);

    // ALU and branch mix, including unsupported encodings that must act as NOPs.
    clear_prog();
    prog[0]  = enc_i(-7, 0, 0, 1);          // x1 = -7
    prog[1]  = enc_i(12, 0, 0, 2);          // x2 = 12
    prog[2]  = enc_r(7'h20, 2, 1, 0, 3);    // sub  x3 = -19
    prog[3]  = enc_r(0, 2, 1, 7, 4);        // and
    prog[4]  = enc_r(0, 2, 1, 6, 5);        // or
    prog[5]  = enc_r(0, 2, 1, 4, 6);        // xor
    prog[6]  = enc_r(0, 1, 2, 3, 7);        // sltu x7,x2,x1
    prog[7]  = enc_i(-6, 1, 2, 8);          // slti
    prog[8]  = enc_i(5, 1, 3, 9);           // sltiu
    prog[9]  = enc_i(-1, 1, 4, 10);         // xori x10 = 6
    prog[10] = enc_i(3, 2, 6, 11);          // ori
    prog[11] = enc_i(15, 1, 7, 12);         // andi
    prog[12] = enc_b(8, 2, 1, 5);           // bge  not taken
    prog[13] = enc_b(8, 1, 2, 6);           // bltu taken
    prog[14] = enc_i(1, 0, 0, 13);          // skipped
    prog[15] = enc_b(8, 2, 1, 7);           // bgeu taken
    prog[16] = enc_i(1, 0, 0, 14);          // skipped
    prog[17] = enc_b(8, 2, 1, 0);           // beq  not taken
    prog[18] = enc_b(8, 1, 1, 1);           // bne  not taken
    prog[19] = enc_i(1, 1, 1, 15);          // slli: NOP here
    prog[20] = enc_r(7'h01, 2, 1, 0, 16);   // mul encoding: NOP
    prog[21] = enc_r(7'h20, 2, 1, 7, 17);   // bad funct7/funct3: NOP
    prog[22] = enc_i(1, 0, 0, 18);
    start_prog();
    step(21);
    check32("sub_x3", dut.reg_file.registers[3], 32'hFFFFFFED);
    check32("xori_x10", dut.reg_file.registers[10], 32'd6);
    check32("andi_x12", dut.reg_file.registers[12], 32'd9);
    check32("slli_nop_x15", dut.reg_file.registers[15], 32'd0);
    check32("mix_x18", dut.reg_file.registers[18], 32'd1);

    // Illegal word and fetch wrap-around past the memory depth.
    clear_prog();
    prog[0]  = enc_i(3, 0, 0, 1);      // addi x1,x0,3
    prog[1]  = 32'hFFFFFFFF;
    prog[63] = enc_i(1, 1, 0, 1);      // addi x1,x1,1
    start_prog();
    step(2);
    check32("illegal_pc", dut.pc, 32'h8);
    check32("illegal_x1", dut.reg_file.registers[1], 32'd3);
    step(62);
    check32("wrap_last_x1", dut.reg_file.registers[1], 32'd4);
    step(6);
    check32("wrap_pc", dut.pc, 32'h118);
    check32("wrap_refetch_x1", dut.reg_file.registers[1], 32'd3);

    @(negedge clk);
    #1;
    active = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
